// File: rtl/counter_req_scheduler.sv
// Round-robin scheduler sharing one up/down counter between NUM_REQ requesters.
// Rising edges of req_inc/req_dec latch pending ops; one requester is served per 2-cycle slot.
module counter_req_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req_inc,
  input  logic [NUM_REQ-1:0] req_dec,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic [WIDTH-1:0]   count,
  output logic               boundary
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, SERVE} state_t;

  state_t             state_q;
  logic [NUM_REQ-1:0] req_inc_q, req_dec_q;
  logic [NUM_REQ-1:0] pend_inc_q, pend_dec_q;
  logic [NUM_REQ-1:0] pend_inc_d, pend_dec_d;
  logic [NUM_REQ-1:0] clr_mask;
  logic [IDXW-1:0]    sel_q, rr_ptr_q, rr_ptr_d, pick;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [NUM_REQ-1:0] grant_q;
  logic               boundary_q, boundary_d;
  logic               any_pend, op_inc, op_dec;
  int                 scan_idx;

  assign clr_mask = (state_q == SERVE) ? (NUM_REQ'(1) << sel_q) : '0;

  // Set wins over clear: a fresh edge in the serve cycle re-arms the flag.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pend
    assign pend_inc_d[gi] = (pend_inc_q[gi] & ~clr_mask[gi]) | (req_inc[gi] & ~req_inc_q[gi]);
    assign pend_dec_d[gi] = (pend_dec_q[gi] & ~clr_mask[gi]) | (req_dec[gi] & ~req_dec_q[gi]);
  end

  // Scan downward so the last hit written is the first pending slot at or after rr_ptr.
  always_comb begin
    any_pend = |(pend_inc_q | pend_dec_q);
    pick     = rr_ptr_q;
    scan_idx = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = int'(rr_ptr_q) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      if (pend_inc_q[scan_idx] | pend_dec_q[scan_idx]) pick = IDXW'(scan_idx);
    end
  end

  always_comb begin
    op_inc     = pend_inc_q[sel_q] & ~pend_dec_q[sel_q];
    op_dec     = pend_dec_q[sel_q] & ~pend_inc_q[sel_q];
    count_d    = count_q;
    boundary_d = 1'b0;
    if (op_inc) begin
      if (count_q == {WIDTH{1'b1}}) begin
        boundary_d = 1'b1;
        count_d    = SATURATE ? count_q : '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end else if (op_dec) begin
      if (count_q == '0) begin
        boundary_d = 1'b1;
        count_d    = SATURATE ? count_q : {WIDTH{1'b1}};
      end else begin
        count_d = count_q - 1'b1;
      end
    end
    rr_ptr_d = (sel_q == IDXW'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      req_inc_q  <= '0;
      req_dec_q  <= '0;
      pend_inc_q <= '0;
      pend_dec_q <= '0;
      sel_q      <= '0;
      rr_ptr_q   <= '0;
      count_q    <= '0;
      grant_q    <= '0;
      boundary_q <= 1'b0;
    end else begin
      req_inc_q  <= req_inc;
      req_dec_q  <= req_dec;
      pend_inc_q <= pend_inc_d;
      pend_dec_q <= pend_dec_d;
      grant_q    <= '0;
      boundary_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable && any_pend) begin
            sel_q   <= pick;
            state_q <= SERVE;
          end
        end
        SERVE: begin
          state_q    <= IDLE;
          count_q    <= count_d;
          boundary_q <= boundary_d;
          grant_q    <= NUM_REQ'(1) << sel_q;
          rr_ptr_q   <= rr_ptr_d;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant    = grant_q;
  assign boundary = boundary_q;
  assign count    = count_q;
  assign busy     = any_pend | (state_q == SERVE);

endmodule
